// File: rtl/xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module  : xpb_table_gen
// Brief   : Streams the xpb table entries (j*B) mod N, j = 0..2^IDX_W-1, to a
//           RAM write port using a chunked modular adder.
// Rev     : 1.0 - initial release
// ============================================================================
module xpb_table_gen #(
    parameter int DATA_W  = 1024,
    parameter int IDX_W   = 5,
    parameter int CHUNK_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] modulus_in,
    input  logic [DATA_W-1:0] base_in,
    output logic              busy,
    output logic              done,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int c_nch   = DATA_W / CHUNK_W;
    localparam int c_cnt_w = (c_nch > 1) ? $clog2(c_nch) : 1;
    localparam logic [c_cnt_w-1:0] c_last_chunk = c_cnt_w'(c_nch - 1);
    localparam logic [IDX_W-1:0]   c_last_idx   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_ADD    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [DATA_W-1:0]         r_n;
    logic [DATA_W-1:0]         r_b;
    logic [DATA_W-1:0]         r_acc;
    logic [DATA_W-CHUNK_W-1:0] r_sum;
    logic [DATA_W-CHUNK_W-1:0] r_diff;
    logic [IDX_W-1:0]          r_idx;
    logic [c_cnt_w-1:0]        r_chunk;
    logic                      r_carry;
    logic                      r_borrow;

    logic [CHUNK_W:0]   w_sum;
    logic [CHUNK_W:0]   w_diff;
    logic [DATA_W-1:0]  w_sum_next;
    logic [DATA_W-1:0]  w_diff_next;
    logic               w_use_diff;
    logic [DATA_W-1:0]  w_result;

    // Operands are rotated right each ADD cycle so the active chunk is always the LSB slice
    assign w_sum  = {1'b0, r_acc[CHUNK_W-1:0]} + {1'b0, r_b[CHUNK_W-1:0]}
                  + {{CHUNK_W{1'b0}}, r_carry};
    assign w_diff = {1'b0, w_sum[CHUNK_W-1:0]} - {1'b0, r_n[CHUNK_W-1:0]}
                  - {{CHUNK_W{1'b0}}, r_borrow};

    assign w_sum_next  = {w_sum[CHUNK_W-1:0], r_sum};
    assign w_diff_next = {w_diff[CHUNK_W-1:0], r_diff};
    assign w_use_diff  = w_sum[CHUNK_W] | ~w_diff[CHUNK_W];
    assign w_result    = w_use_diff ? w_diff_next : w_sum_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_WRITE;
            S_WRITE:  w_next_state = (r_idx == c_last_idx) ? S_FINISH : S_ADD;
            S_ADD:    if (r_chunk == c_last_chunk) w_next_state = S_WRITE;
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_sum    <= '0;
            r_diff   <= '0;
            r_idx    <= '0;
            r_chunk  <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            busy  <= (w_next_state == S_WRITE) || (w_next_state == S_ADD);
            done  <= (w_next_state == S_FINISH);
            wr_en <= (w_next_state == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_n     <= modulus_in;
                        r_b     <= base_in;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        wr_addr <= '0;
                        wr_data <= '0;
                    end
                end
                S_WRITE: begin
                    r_chunk  <= '0;
                    r_carry  <= 1'b0;
                    r_borrow <= 1'b0;
                    if (r_idx != c_last_idx) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_ADD: begin
                    r_carry  <= w_sum[CHUNK_W];
                    r_borrow <= w_diff[CHUNK_W];
                    r_sum    <= w_sum_next[DATA_W-1:CHUNK_W];
                    r_diff   <= w_diff_next[DATA_W-1:CHUNK_W];
                    r_b      <= {r_b[CHUNK_W-1:0], r_b[DATA_W-1:CHUNK_W]};
                    r_n      <= {r_n[CHUNK_W-1:0], r_n[DATA_W-1:CHUNK_W]};
                    r_chunk  <= r_chunk + c_cnt_w'(1);
                    if (r_chunk == c_last_chunk) begin
                        r_acc   <= w_result;
                        wr_addr <= r_idx;
                        wr_data <= w_result;
                    end else begin
                        r_acc <= {r_acc[CHUNK_W-1:0], r_acc[DATA_W-1:CHUNK_W]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xpb_table_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_xpb_table_gen
// Brief   : Directed self-checking bench for xpb_table_gen (default + small config).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_xpb_table_gen;

    localparam int DW = 1024;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] modulus_in = '0;
    logic [DW-1:0] base_in = '0;
    logic          busy, done, wr_en;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          start_s = 1'b0;
    logic [15:0]   mod_s = '0;
    logic [15:0]   base_s = '0;
    logic          busy_s, done_s, wr_en_s;
    logic [IW-1:0] wr_addr_s;
    logic [15:0]   wr_data_s;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] cap_data[$];
    int            cap_addr[$];
    int            cap_cyc[$];
    int            done_cyc[$];
    bit            busy_tr[0:511];
    bit            act_tr[0:511];

    xpb_table_gen u_dut (
        .clk(clk), .rst(rst), .start(start),
        .modulus_in(modulus_in), .base_in(base_in),
        .busy(busy), .done(done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    xpb_table_gen #(.DATA_W(16), .IDX_W(5), .CHUNK_W(4)) u_small (
        .clk(clk), .rst(rst), .start(start_s),
        .modulus_in(mod_s), .base_in(base_s),
        .busy(busy_s), .done(done_s), .wr_en(wr_en_s),
        .wr_addr(wr_addr_s), .wr_data(wr_data_s)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ref_entry(input int j, input logic [DW-1:0] n,
                                                input logic [DW-1:0] b);
        logic [DW:0] a;
        a = '0;
        for (int i = 0; i < j; i++) begin
            a = a + {1'b0, b};
            if (a >= {1'b0, n}) a = a - {1'b0, n};
        end
        return a[DW-1:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Starts the default DUT and records writes/done/busy per cycle after the start edge
    task automatic run_capture(input logic [DW-1:0] n, input logic [DW-1:0] b,
                               input int p1, input int p2, input int p3,
                               input int rst_at, input int max_cyc);
        cap_data.delete();
        cap_addr.delete();
        cap_cyc.delete();
        done_cyc.delete();
        for (int i = 0; i < 512; i++) begin
            busy_tr[i] = 1'b0;
            act_tr[i]  = 1'b0;
        end
        modulus_in = n;
        base_in    = b;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= max_cyc; k++) begin
            busy_tr[k] = busy;
            act_tr[k]  = busy | done | wr_en;
            if (wr_en) begin
                cap_data.push_back(wr_data);
                cap_addr.push_back(int'(wr_addr));
                cap_cyc.push_back(k);
            end
            if (done) done_cyc.push_back(k);
            start = (k == p1) || (k == p2) || (k == p3);
            rst   = (k == rst_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
        n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data[127:0]); end
        n_cmp++; if ({busy_s, done_s, wr_en_s} !== 3'b000 || wr_data_s !== 16'h0) begin
            n_err++; $display("FAIL reset_small: got %b/%h want 000/0000", {busy_s, done_s, wr_en_s}, wr_data_s);
        end
        start = 1'b0;
        start_s = 1'b0;
        do_reset();
    endtask

    task automatic test_small();
        logic [15:0] s_data[0:63];
        int          s_addr[0:63];
        int          s_cyc[0:63];
        int          cnt;
        int          dcnt;
        int          dcyc;
        cnt = 0; dcnt = 0; dcyc = -1;
        do_reset();
        mod_s = 16'hFFF1;
        base_s = 16'h1234;
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (wr_en_s && cnt < 64) begin
                s_data[cnt] = wr_data_s;
                s_addr[cnt] = int'(wr_addr_s);
                s_cyc[cnt]  = k;
                cnt++;
            end
            if (done_s) begin dcnt++; dcyc = k; end
            @(posedge clk);
            #1;
        end
        n_cmp++; if (cnt !== 32) begin n_err++; $display("FAIL small_count: got %0d want 32", cnt); end
        if (cnt == 32) begin
            n_cmp++; if (s_data[0] !== 16'h0000) begin n_err++; $display("FAIL small_e0: got %h want 0000", s_data[0]); end
            n_cmp++; if (s_data[1] !== 16'h1234) begin n_err++; $display("FAIL small_e1: got %h want 1234", s_data[1]); end
            n_cmp++; if (s_data[14] !== 16'hFED8) begin n_err++; $display("FAIL small_e14: got %h want fed8", s_data[14]); end
            n_cmp++; if (s_data[15] !== 16'h111B) begin n_err++; $display("FAIL small_e15: got %h want 111b", s_data[15]); end
            n_cmp++; if (s_data[31] !== 16'h346A) begin n_err++; $display("FAIL small_e31: got %h want 346a", s_data[31]); end
            for (int j = 0; j < 32; j++) begin
                n_cmp++;
                if (s_addr[j] !== j || s_cyc[j] !== 1 + 5 * j) begin
                    n_err++; $display("FAIL small_addr[%0d]: got %0d@%0d want %0d@%0d", j, s_addr[j], s_cyc[j], j, 1 + 5 * j);
                end
            end
            n_cmp++; if (dcnt !== 1 || dcyc !== s_cyc[31] + 1) begin
                n_err++; $display("FAIL small_done: got %0d pulses @%0d want 1 @%0d", dcnt, dcyc, s_cyc[31] + 1);
            end
        end
    endtask

    task automatic test_carry_out();
        logic [DW-1:0] n, b, exp;
        do_reset();
        n = '1;
        b = n - 1;
        run_capture(n, b, -1, -1, -1, -1, 300);
        n_cmp++; if (cap_cyc.size() !== 32) begin n_err++; $display("FAIL carry_count: got %0d want 32", cap_cyc.size()); end
        for (int j = 0; j < 32 && j < cap_cyc.size(); j++) begin
            exp = (j == 0) ? '0 : n - DW'(j);
            n_cmp++;
            if (cap_data[j] !== exp || cap_addr[j] !== j || cap_cyc[j] !== 1 + 9 * j) begin
                n_err++; $display("FAIL carry_entry[%0d]: got %h a%0d @%0d want %h a%0d @%0d", j,
                                  cap_data[j][127:0], cap_addr[j], cap_cyc[j], exp[127:0], j, 1 + 9 * j);
            end
        end
        exp = '1;
        exp[1] = 1'b0;
        if (cap_cyc.size() > 2) begin
            n_cmp++; if (cap_data[2] !== exp) begin n_err++; $display("FAIL carry_e2: got %h want ...fffd", cap_data[2][127:0]); end
        end
        n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 281) begin
            n_err++; $display("FAIL carry_done: got %0d pulses first @%0d want 1 @281", done_cyc.size(),
                              (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        n_cmp++; if ({busy_tr[1], busy_tr[280], busy_tr[281]} !== 3'b110) begin
            n_err++; $display("FAIL carry_busy: got %b want 110", {busy_tr[1], busy_tr[280], busy_tr[281]});
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] n, b, exp;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int i = 0; i < 32; i++) begin
                n[i*32 +: 32] = $urandom();
                b[i*32 +: 32] = $urandom();
            end
            n[DW-1] = 1'b1;
            n[0] = 1'b1;
            if (b >= n) b = b - n;
            run_capture(n, b, -1, -1, -1, -1, 300);
            n_cmp++; if (cap_cyc.size() !== 32) begin n_err++; $display("FAIL rand_count: got %0d want 32", cap_cyc.size()); end
            for (int j = 0; j < 32 && j < cap_cyc.size(); j++) begin
                exp = ref_entry(j, n, b);
                n_cmp++;
                if (cap_data[j] !== exp || cap_addr[j] !== j) begin
                    n_err++; $display("FAIL rand_entry[%0d]: got %h a%0d want %h a%0d", j,
                                      cap_data[j][127:0], cap_addr[j], exp[127:0], j);
                end
                if (j > 0) begin
                    n_cmp++;
                    if (cap_cyc[j] - cap_cyc[j-1] !== 9) begin
                        n_err++; $display("FAIL rand_spacing[%0d]: got %0d want 9", j, cap_cyc[j] - cap_cyc[j-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [DW-1:0] n, b;
        do_reset();
        n = {4'h9, {(DW-8){1'b0}}, 4'h7};
        b = {4'h3, {(DW-8){1'b1}}, 4'h5};
        run_capture(n, b, 5, 100, 281, -1, 320);
        n_cmp++; if (cap_cyc.size() !== 32) begin n_err++; $display("FAIL ign_count: got %0d want 32", cap_cyc.size()); end
        for (int j = 0; j < 32 && j < cap_cyc.size(); j++) begin
            n_cmp++;
            if (cap_addr[j] !== j || cap_data[j] !== ref_entry(j, n, b)) begin
                n_err++; $display("FAIL ign_entry[%0d]: got a%0d want a%0d", j, cap_addr[j], j);
            end
        end
        n_cmp++; if (done_cyc.size() !== 1) begin n_err++; $display("FAIL ign_done: got %0d pulses want 1", done_cyc.size()); end
        n_cmp++; if (busy_tr[282] !== 1'b0 || busy_tr[300] !== 1'b0) begin
            n_err++; $display("FAIL ign_restart: got busy %b%b want 00", busy_tr[282], busy_tr[300]);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] n, b;
        int            quiet_bad;
        do_reset();
        n = '1;
        n[DW-1] = 1'b0;
        b = {2'b01, {(DW-4){1'b0}}, 2'b11};
        run_capture(n, b, 60, -1, -1, 50, 360);
        quiet_bad = 0;
        for (int k = 51; k <= 60; k++) if (act_tr[k]) quiet_bad++;
        n_cmp++; if (quiet_bad !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", quiet_bad); end
        n_cmp++; if (cap_cyc.size() !== 38) begin n_err++; $display("FAIL abort_count: got %0d want 38", cap_cyc.size()); end
        if (cap_cyc.size() == 38) begin
            for (int j = 0; j < 6; j++) begin
                n_cmp++;
                if (cap_addr[j] !== j || cap_cyc[j] !== 1 + 9 * j) begin
                    n_err++; $display("FAIL abort_pre[%0d]: got a%0d @%0d want a%0d @%0d", j, cap_addr[j], cap_cyc[j], j, 1 + 9 * j);
                end
            end
            for (int j = 0; j < 32; j++) begin
                n_cmp++;
                if (cap_addr[6+j] !== j || cap_cyc[6+j] !== 61 + 9 * j || cap_data[6+j] !== ref_entry(j, n, b)) begin
                    n_err++; $display("FAIL abort_post[%0d]: got a%0d @%0d want a%0d @%0d", j,
                                      cap_addr[6+j], cap_cyc[6+j], j, 61 + 9 * j);
                end
            end
        end
        n_cmp++; if (done_cyc.size() !== 1 || done_cyc[0] !== 341) begin
            n_err++; $display("FAIL abort_done: got %0d pulses first @%0d want 1 @341", done_cyc.size(),
                              (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_small();
        test_carry_out();
        test_random();
        test_start_ignored();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
